// File: rtl/operand_sequencer_if.sv
// operand_sequencer_if
//   Bundles the calculator sequencer's user/ALU/display signals.
//   Parameter NBYTES sets operand width W = 8*NBYTES and byte index width IDXW.
//   slave  : the sequencer (takes enter/switch/ALU inputs, drives operands,
//            ALU strobe and display fields).
//   master : whoever drives the user and ALU side (datapath or testbench).
interface operand_sequencer_if #(
   parameter int NBYTES = 4
);
   localparam int W    = 8 * NBYTES;
   localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   logic            enter_pulse;
   logic [7:0]      inputdata;
   logic            alu_done;
   logic [W-1:0]    dataR;
   logic [W-1:0]    dataA;
   logic [W-1:0]    dataB;
   logic            alu_start;
   logic            inputdata_ready;
   logic            busy;
   logic [3:0]      field;
   logic [IDXW-1:0] byte_idx;
   logic [7:0]      disp_byte;

   modport master (
      output enter_pulse, inputdata, alu_done, dataR,
      input  dataA, dataB, alu_start, inputdata_ready, busy, field, byte_idx, disp_byte
   );

   modport slave (
      input  enter_pulse, inputdata, alu_done, dataR,
      output dataA, dataB, alu_start, inputdata_ready, busy, field, byte_idx, disp_byte
   );
endinterface

// File: rtl/operand_sequencer.sv
// operand_sequencer
//   Sequences byte-serial entry of operands A and B (LSB byte first), an ALU
//   start/done handshake with timeout, and byte-by-byte result display.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : operand_sequencer_if.slave (enter_pulse, inputdata, alu_done, dataR in;
//           dataA, dataB, alu_start, inputdata_ready, busy, field, byte_idx,
//           disp_byte out)
// Build option:
//   AUTO_SCROLL_EN : when defined, SHOW_R auto-advances byte_idx every
//                    SCROLL_DIV cycles and any enter_pulse returns to LOAD_A.
module operand_sequencer #(
   parameter int NBYTES      = 4,
   parameter int ALU_TIMEOUT = 255,
   parameter int SCROLL_DIV  = 50000000
) (
   input logic                clk,
   input logic                reset,
   operand_sequencer_if.slave bus
);
   localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int CW   = $clog2(ALU_TIMEOUT + 1);

   localparam logic [1:0] S_LOAD_A = 2'd0;
   localparam logic [1:0] S_LOAD_B = 2'd1;
   localparam logic [1:0] S_EXEC   = 2'd2;
   localparam logic [1:0] S_SHOW_R = 2'd3;

   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);
   localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
   localparam logic [CW-1:0]   CNT_TO   = CW'(ALU_TIMEOUT);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   // Reject out-of-range configurations at elaboration.
   if (NBYTES < 2 || NBYTES > 8 || ALU_TIMEOUT < 1 || SCROLL_DIV < 1) begin : g_bad_param
      $error("operand_sequencer: illegal parameter value");
   end

   logic [1:0]             r_state;
   logic [NBYTES-1:0][7:0] r_a;
   logic [NBYTES-1:0][7:0] r_b;
   logic [NBYTES-1:0][7:0] r_res;
   logic [IDXW-1:0]        r_idx;
   logic [CW-1:0]          r_cnt;
   logic                   r_err;
   logic                   r_ready;
   logic                   w_last;
   logic [3:0]             w_field;
   logic [7:0]             w_disp;

`ifdef AUTO_SCROLL_EN
   localparam int SC_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam logic [SC_W-1:0] SC_TC  = SC_W'(SCROLL_DIV - 1);
   localparam logic [SC_W-1:0] SC_ONE = SC_W'(1);
   logic [SC_W-1:0] r_scnt;
`endif

   assign w_last = (r_idx == IDX_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_LOAD_A;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_ready <= 1'b0;
`ifdef AUTO_SCROLL_EN
         r_scnt  <= '0;
`endif
      end else begin
         r_ready <= 1'b0;
`ifdef AUTO_SCROLL_EN
         // Held at zero outside SHOW_R so every SHOW_R visit starts a fresh period.
         if (r_state != S_SHOW_R) r_scnt <= '0;
`endif
         case (r_state)
            S_LOAD_A: if (bus.enter_pulse) begin
               r_a[r_idx] <= bus.inputdata;
               r_ready    <= 1'b1;
               if (w_last) begin
                  r_idx   <= '0;
                  r_state <= S_LOAD_B;
               end else r_idx <= r_idx + IDX_ONE;
            end
            S_LOAD_B: if (bus.enter_pulse) begin
               r_b[r_idx] <= bus.inputdata;
               r_ready    <= 1'b1;
               if (w_last) begin
                  r_idx   <= '0;
                  r_state <= S_EXEC;
               end else r_idx <= r_idx + IDX_ONE;
            end
            S_EXEC: begin
               // done has priority over timeout; counter returns to 0 on exit.
               if (bus.alu_done) begin
                  r_res   <= bus.dataR;
                  r_err   <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_SHOW_R;
               end else if (r_cnt == CNT_TO) begin
                  r_res   <= '0;
                  r_err   <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_SHOW_R;
               end else r_cnt <= r_cnt + CNT_ONE;
            end
            S_SHOW_R: begin
`ifdef AUTO_SCROLL_EN
               if (bus.enter_pulse) begin
                  r_idx   <= '0;
                  r_a     <= '0;
                  r_b     <= '0;
                  r_err   <= 1'b0;
                  r_state <= S_LOAD_A;
               end else if (r_scnt == SC_TC) begin
                  r_scnt <= '0;
                  r_idx  <= w_last ? '0 : r_idx + IDX_ONE;
               end else r_scnt <= r_scnt + SC_ONE;
`else
               if (bus.enter_pulse) begin
                  if (w_last) begin
                     r_idx   <= '0;
                     r_a     <= '0;
                     r_b     <= '0;
                     r_err   <= 1'b0;
                     r_state <= S_LOAD_A;
                  end else r_idx <= r_idx + IDX_ONE;
               end
`endif
            end
            default: r_state <= S_LOAD_A;
         endcase
      end
   end

   // Display routing: live switch preview while loading, latched result in SHOW_R.
   always_comb begin
      w_field = 4'hC;
      w_disp  = 8'h00;
      case (r_state)
         S_LOAD_A: begin
            w_field = 4'hA;
            w_disp  = bus.inputdata;
         end
         S_LOAD_B: begin
            w_field = 4'hB;
            w_disp  = bus.inputdata;
         end
         S_SHOW_R: begin
            w_field = r_err ? 4'hE : 4'hC;
            w_disp  = r_res[r_idx];
         end
         default: ;
      endcase
   end

   // alu_start is decoded from state so an async reset drops it immediately.
   assign bus.alu_start       = (r_state == S_EXEC) && (r_cnt == '0);
   assign bus.busy            = (r_state == S_EXEC);
   assign bus.dataA           = r_a;
   assign bus.dataB           = r_b;
   assign bus.inputdata_ready = r_ready;
   assign bus.byte_idx        = r_idx;
   assign bus.field           = w_field;
   assign bus.disp_byte       = w_disp;
endmodule

// File: tb/tb_operand_sequencer.sv
module tb_operand_sequencer;
   localparam int NB = 4;
   localparam int W  = 8 * NB;
   localparam int TO = 7;
   localparam int SD = 4;

   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   ready_cnt = 0;
   int   start_cnt = 0;
   logic [W-1:0] exp_a, exp_b;

   operand_sequencer_if #(.NBYTES(NB)) bus ();

   operand_sequencer #(.NBYTES(NB), .ALU_TIMEOUT(TO), .SCROLL_DIV(SD)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.inputdata_ready === 1'b1) ready_cnt++;
      if (bus.alu_start === 1'b1) start_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse();
      @(negedge clk);
      bus.enter_pulse = 1'b1;
      @(negedge clk);
      bus.enter_pulse = 1'b0;
      #1;
   endtask

   // Enters nb bytes of v, LSB first, into operand A or B.
   task automatic load_op(input logic [W-1:0] v, input bit is_b, input int nb);
      logic [7:0] b;
      int r0;
      r0 = ready_cnt;
      for (int k = 0; k < nb; k++) begin
         b = 8'(v >> (8 * k));
         @(negedge clk);
         bus.enter_pulse = 1'b1;
         bus.inputdata   = b;
         #1;
         chk("preview", bus.disp_byte, b);
         chk("load_field", bus.field, is_b ? 4'hB : 4'hA);
         chk("load_idx", bus.byte_idx, k);
         @(negedge clk);
         bus.enter_pulse = 1'b0;
         #1;
         if (is_b) exp_b = exp_b | (W'(b) << (8 * k));
         else      exp_a = exp_a | (W'(b) << (8 * k));
         chk("ready", bus.inputdata_ready, 1);
         if (is_b) chk("dataB", bus.dataB, exp_b);
         else      chk("dataA", bus.dataA, exp_a);
      end
      chk("ready_count", ready_cnt - r0, nb);
   endtask

   // One full A/B/EXEC/SHOW round; lat = EXEC cycle in which alu_done is raised
   // (values above TO mean the ALU never answers).
   task automatic txn(input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic [W-1:0] dr, input int lat);
      int c, s0, ncyc;
      logic [W-1:0] res;
      logic [3:0] fexp;
      exp_a = '0;
      exp_b = '0;
      bus.dataR    = dr;
      bus.alu_done = 1'b0;
      load_op(va, 1'b0, NB);
      chk("a_to_b_field", bus.field, 4'hB);
      chk("a_to_b_idx", bus.byte_idx, 0);
      s0 = start_cnt;
      load_op(vb, 1'b1, NB);
      chk("start", bus.alu_start, 1);
      chk("busy", bus.busy, 1);
      c = 0;
      while (bus.busy === 1'b1 && c < TO + 10) begin
         bus.alu_done    = (c == lat);
         bus.enter_pulse = (c == 1);
         @(negedge clk);
         c++;
      end
      bus.alu_done    = 1'b0;
      bus.enter_pulse = 1'b0;
      ncyc = ((lat <= TO) ? lat : TO) + 1;
      chk("exec_cycles", c, ncyc);
      chk("start_once", start_cnt - s0, 1);
      chk("hold_a", bus.dataA, exp_a);
      chk("hold_b", bus.dataB, exp_b);
      res  = (lat <= TO) ? dr : '0;
      fexp = (lat <= TO) ? 4'hC : 4'hE;
      bus.dataR = ~dr;
`ifdef AUTO_SCROLL_EN
      chk("show_field", bus.field, fexp);
      for (int j = 0; j <= SD * NB; j++) begin
         chk("scroll_byte", bus.disp_byte, 8'(res >> (8 * ((j / SD) % NB))));
         @(negedge clk);
      end
      pulse();
`else
      for (int k = 0; k < NB; k++) begin
         chk("show_field", bus.field, fexp);
         chk("show_idx", bus.byte_idx, k);
         chk("show_byte", bus.disp_byte, 8'(res >> (8 * k)));
         chk("no_ready", bus.inputdata_ready, 0);
         pulse();
      end
`endif
      chk("back_field", bus.field, 4'hA);
      chk("back_idx", bus.byte_idx, 0);
      chk("back_a", bus.dataA, 0);
      chk("back_b", bus.dataB, 0);
   endtask

   task automatic reset_state_chk(input string tag);
      chk({tag, "_field"}, bus.field, 4'hA);
      chk({tag, "_start"}, bus.alu_start, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_ready"}, bus.inputdata_ready, 0);
      chk({tag, "_idx"}, bus.byte_idx, 0);
      chk({tag, "_a"}, bus.dataA, 0);
      chk({tag, "_b"}, bus.dataB, 0);
   endtask

   initial begin
      int s;
      reset           = 1'b0;
      bus.enter_pulse = 1'b0;
      bus.inputdata   = 8'h00;
      bus.alu_done    = 1'b0;
      bus.dataR       = '0;
      #12;
      reset_state_chk("reset");
      #10 reset = 1'b1;

      // Directed rounds: normal, timeout, done on the timeout cycle, zero-wait.
      txn(32'h44332211, 32'hDDCCBBAA, 32'h12345678, 3);
      txn($urandom, $urandom, $urandom, 1000);
      txn($urandom, $urandom, $urandom, TO);
      txn($urandom, $urandom, $urandom, 0);
      txn($urandom, $urandom, 32'h01020304, 3);

      // Reset in the first EXEC cycle: alu_start must drop without a clock edge.
      exp_a = '0;
      exp_b = '0;
      load_op($urandom, 1'b0, NB);
      load_op($urandom, 1'b1, NB);
      chk("pre_rst_start", bus.alu_start, 1);
      #1 reset = 1'b0;
      #1;
      reset_state_chk("rst_exec");
      #1 reset = 1'b1;
      s = start_cnt;
      repeat (10) @(negedge clk);
      chk("no_start_after_rst", start_cnt - s, 0);

      // Reset partway through operand B.
      exp_a = '0;
      exp_b = '0;
      load_op($urandom, 1'b0, NB);
      load_op($urandom, 1'b1, 2);
      chk("midb_idx", bus.byte_idx, 2);
      chk("midb_field", bus.field, 4'hB);
      #1 reset = 1'b0;
      #1;
      reset_state_chk("rst_loadb");
      #1 reset = 1'b1;
      s = start_cnt;
      repeat (10) @(negedge clk);
      chk("no_start_after_rst2", start_cnt - s, 0);

      // Randomized rounds.
      for (int i = 0; i < 6; i++)
         txn($urandom, $urandom, $urandom, int'($urandom_range(0, TO + 3)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
